// File: rtl/crc_ccitt_pkg.sv
// Shared CRC-16-CCITT definitions used by both the frame generator and the frame checker.
// Keeping the byte-step function here makes the two ends bit-identical by construction.
package crc_ccitt_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Two CRC bytes plus at least one payload byte.
    localparam logic [15:0] MIN_FRAME_LEN = 16'd3;

    typedef enum logic [1:0] {
        ErrNone     = 2'b00,
        ErrCrc      = 2'b01,
        ErrRunt     = 2'b10,
        ErrOversize = 2'b11
    } frame_err_e;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StDrain,
        StResult
    } chk_state_e;

    // MSB-first, non-reflected update of the CRC register by one byte.
    function automatic logic [15:0] crc_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ({16{c[15] ^ data[i]}} & CRC_POLY);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational one-byte CRC-16-CCITT step; a thin wrapper of the shared package function.
module crc16_ccitt_byte
    import crc_ccitt_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_ccitt_byte(crc_in, data);
    end

endmodule

// File: rtl/crc_ccitt_frame_checker.sv
// Receive-side CRC-16-CCITT frame checker: per-frame verdict, length, residue and
// saturating good/bad frame statistics.
module crc_ccitt_frame_checker
    import crc_ccitt_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,

    output logic             frame_valid,
    output logic             frame_ok,
    output logic [1:0]       frame_err_code,
    output logic [15:0]      frame_len,
    output logic [15:0]      crc_residue,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [15:0] MaxLen = 16'(MAX_LEN);

    chk_state_e state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;

    logic             frame_valid_q, frame_valid_d;
    logic             frame_ok_q, frame_ok_d;
    frame_err_e       err_code_q, err_code_d;
    logic [15:0]      frame_len_q, frame_len_d;
    logic [15:0]      residue_q, residue_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        accept;
    logic        last_accept;
    logic [15:0] crc_base;
    logic [15:0] crc_next;
    logic [15:0] crc_fin;
    logic [15:0] len_base;
    logic [15:0] len_inc;
    frame_err_e  verdict;

    // s_ready is a pure function of state, so no combinational path from s_valid.
    assign s_ready     = (state_q != StResult);
    assign accept      = s_valid && s_ready;
    assign last_accept = accept && s_last;

    // IDLE starts a fresh frame regardless of whatever the registers still hold.
    assign crc_base = (state_q == StIdle) ? CRC_INIT : crc_q;
    assign len_base = (state_q == StIdle) ? 16'd0 : len_q;
    assign len_inc  = (len_base == 16'hFFFF) ? len_base : len_base + 16'd1;

    crc16_ccitt_byte u_crc_step (
        .crc_in  (crc_base),
        .data    (s_data),
        .crc_out (crc_next)
    );

    // Draining bytes are discarded, so the residue stays at its frozen value.
    assign crc_fin = (state_q == StDrain) ? crc_q : crc_next;

    always_comb begin
        if (len_inc > MaxLen) begin
            verdict = ErrOversize;
        end else if (len_inc < MIN_FRAME_LEN) begin
            verdict = ErrRunt;
        end else if (crc_fin != 16'h0000) begin
            verdict = ErrCrc;
        end else begin
            verdict = ErrNone;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle, StData: begin
                if (accept) begin
                    crc_d = crc_next;
                    len_d = len_inc;
                    if (s_last) begin
                        state_d = StResult;
                    end else if (len_inc > MaxLen) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StDrain: begin
                if (accept) begin
                    len_d = len_inc;
                    if (s_last) begin
                        state_d = StResult;
                    end
                end
            end
            StResult: begin
                state_d = StIdle;
                crc_d   = CRC_INIT;
                len_d   = 16'd0;
            end
            default: begin
                state_d = StIdle;
                crc_d   = CRC_INIT;
                len_d   = 16'd0;
            end
        endcase
    end

    // Verdict fields are captured with the last byte and then held until the next frame ends.
    always_comb begin
        frame_valid_d = last_accept;
        frame_ok_d    = frame_ok_q;
        err_code_d    = err_code_q;
        frame_len_d   = frame_len_q;
        residue_d     = residue_q;
        ok_cnt_d      = ok_cnt_q;
        err_cnt_d     = err_cnt_q;
        if (last_accept) begin
            frame_ok_d  = (verdict == ErrNone);
            err_code_d  = verdict;
            frame_len_d = len_inc;
            residue_d   = crc_fin;
            if (verdict == ErrNone) begin
                if (ok_cnt_q != {CNT_W{1'b1}}) begin
                    ok_cnt_d = ok_cnt_q + 1'b1;
                end
            end else begin
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            crc_q         <= CRC_INIT;
            len_q         <= 16'd0;
            frame_valid_q <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_code_q    <= ErrNone;
            frame_len_q   <= 16'd0;
            residue_q     <= CRC_INIT;
            ok_cnt_q      <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            frame_valid_q <= frame_valid_d;
            frame_ok_q    <= frame_ok_d;
            err_code_q    <= err_code_d;
            frame_len_q   <= frame_len_d;
            residue_q     <= residue_d;
            ok_cnt_q      <= ok_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign frame_valid    = frame_valid_q;
    assign frame_ok       = frame_ok_q;
    assign frame_err_code = err_code_q;
    assign frame_len      = frame_len_q;
    assign crc_residue    = residue_q;
    assign ok_count       = ok_cnt_q;
    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_crc_ccitt_frame_checker.sv
// Scoreboard bench for crc_ccitt_frame_checker: expected verdicts are queued as frames are
// driven and compared when frame_valid pulses.
module tb_crc_ccitt_frame_checker;

    localparam int unsigned MaxLen = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        frame_valid;
    logic        frame_ok;
    logic [1:0]  frame_err_code;
    logic [15:0] frame_len;
    logic [15:0] crc_residue;
    logic [15:0] ok_count;
    logic [15:0] err_count;

    crc_ccitt_frame_checker #(
        .MAX_LEN (MaxLen),
        .CNT_W   (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .frame_valid    (frame_valid),
        .frame_ok       (frame_ok),
        .frame_err_code (frame_err_code),
        .frame_len      (frame_len),
        .crc_residue    (crc_residue),
        .ok_count       (ok_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok;
        logic [1:0]  code;
        logic [15:0] len;
        logic [15:0] res;
        bit          chk_res;
        int          cyc;
        logic [15:0] okc;
        logic [15:0] errc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   m_ok   = 0;
    int   m_err  = 0;

    logic [7:0] good11 [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial reference: poly 0x1021, MSB first, register seeded with all ones.
    function automatic logic [15:0] model_crc(input logic [7:0] q[$], input int n);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                if (r[15] ^ q[i][b]) r = {r[14:0], 1'b0} ^ 16'h1021;
                else                 r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && frame_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_verdict: frame_valid=1 at cycle %0d, none expected", cyc);
            end else begin
                mon_e = sb.pop_front();
                total++;
                if (cyc !== mon_e.cyc)
                    $display("FAIL verdict_latency: got cycle %0d want %0d", cyc, mon_e.cyc);
                else passed++;
                total++;
                if (frame_ok !== mon_e.ok)
                    $display("FAIL frame_ok: got %b want %b", frame_ok, mon_e.ok);
                else passed++;
                total++;
                if (frame_err_code !== mon_e.code)
                    $display("FAIL frame_err_code: got %b want %b", frame_err_code, mon_e.code);
                else passed++;
                total++;
                if (frame_len !== mon_e.len)
                    $display("FAIL frame_len: got %0d want %0d", frame_len, mon_e.len);
                else passed++;
                if (mon_e.chk_res) begin
                    total++;
                    if (crc_residue !== mon_e.res)
                        $display("FAIL crc_residue: got %h want %h", crc_residue, mon_e.res);
                    else passed++;
                end
                total++;
                if (ok_count !== mon_e.okc)
                    $display("FAIL ok_count: got %0d want %0d", ok_count, mon_e.okc);
                else passed++;
                total++;
                if (err_count !== mon_e.errc)
                    $display("FAIL err_count: got %0d want %0d", err_count, mon_e.errc);
                else passed++;
            end
        end
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap,
                             output int stalls);
        int n;
        stalls = 0;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (s_ready !== 1'b1) begin
            $display("FAIL s_ready_timeout: got %b want 1 within 50 cycles", s_ready);
            $fatal(1, "s_ready never asserted");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gap, output int stalls);
        int   s;
        int   nb;
        exp_t e;
        stalls = 0;
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], (i == f.size() - 1), (i == 0) ? 0 : gap, s);
            stalls += s;
        end
        e.len = 16'(f.size());
        nb = (f.size() > int'(MaxLen)) ? int'(MaxLen) + 1 : f.size();
        e.res = model_crc(f, nb);
        e.chk_res = (f.size() <= int'(MaxLen));
        if (f.size() > int'(MaxLen)) e.code = 2'b11;
        else if (f.size() < 3)        e.code = 2'b10;
        else if (e.res != 16'h0000)   e.code = 2'b01;
        else                          e.code = 2'b00;
        e.ok = (e.code == 2'b00);
        if (e.ok) m_ok++;
        else      m_err++;
        e.okc  = 16'(m_ok);
        e.errc = 16'(m_err);
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_verdicts();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL verdict_timeout: got %0d pending want 0", sb.size());
        else passed++;
    endtask

    task automatic make_good(input int payload, input logic [7:0] seed, output logic [7:0] f[$]);
        logic [15:0] c;
        f.delete();
        for (int i = 0; i < payload; i++) f.push_back(seed + 8'(i * 7));
        c = model_crc(f, f.size());
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_ok  = 0;
        m_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready);
        else passed++;
        total++;
        if (frame_valid !== 1'b0 || frame_ok !== 1'b0 || frame_err_code !== 2'b00)
            $display("FAIL reset_verdict: got v=%b ok=%b code=%b want 0 0 00",
                     frame_valid, frame_ok, frame_err_code);
        else passed++;
        total++;
        if (frame_len !== 16'd0 || crc_residue !== 16'hFFFF)
            $display("FAIL reset_len_residue: got %0d %h want 0 ffff", frame_len, crc_residue);
        else passed++;
        total++;
        if (ok_count !== 16'd0 || err_count !== 16'd0)
            $display("FAIL reset_counters: got %0d %0d want 0 0", ok_count, err_count);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good();
        logic [7:0] f[$];
        int st;
        foreach (good11[i]) f.push_back(good11[i]);
        send_frame(f, 2, st);
        idle(1);
        wait_verdicts();
        idle(3);
        total++;
        if (frame_len !== 16'd11 || frame_ok !== 1'b1 || crc_residue !== 16'h0000)
            $display("FAIL good_hold: got len=%0d ok=%b res=%h want 11 1 0000",
                     frame_len, frame_ok, crc_residue);
        else passed++;
    endtask

    task automatic test_crc_err();
        logic [7:0] f[$];
        int st;
        foreach (good11[i]) f.push_back(good11[i]);
        f[10] = 8'hB0;
        send_frame(f, 0, st);
        idle(2);
        wait_verdicts();
        total++;
        if (crc_residue === 16'h0000 || frame_err_code !== 2'b01)
            $display("FAIL crc_err_residue: got res=%h code=%b want nonzero 01",
                     crc_residue, frame_err_code);
        else passed++;
    endtask

    task automatic test_runt();
        logic [7:0] f[$];
        int st;
        f.push_back(8'h29);
        f.push_back(8'hB1);
        send_frame(f, 0, st);
        idle(2);
        f.delete();
        f.push_back(8'h55);
        send_frame(f, 0, st);
        idle(2);
        wait_verdicts();
    endtask

    task automatic test_oversize();
        logic [7:0] f[$];
        int st;
        for (int i = 0; i < 20; i++) f.push_back(8'(i + 1));
        send_frame(f, 0, st);
        total++;
        if (st !== 0) $display("FAIL drain_s_ready: got %0d stalls want 0", st);
        else passed++;
        idle(2);
        wait_verdicts();
        total++;
        if (frame_err_code !== 2'b11 || frame_len !== 16'd20)
            $display("FAIL oversize_hold: got code=%b len=%0d want 11 20",
                     frame_err_code, frame_len);
        else passed++;
    endtask

    task automatic test_boundary();
        logic [7:0] f[$];
        int st;
        make_good(14, 8'hA0, f);
        send_frame(f, 0, st);
        idle(2);
        make_good(15, 8'h10, f);
        send_frame(f, 1, st);
        idle(2);
        wait_verdicts();
    endtask

    task automatic test_back_to_back();
        logic [7:0] fa[$];
        logic [7:0] fb[$];
        int sa, sbb;
        do_reset();
        foreach (good11[i]) fa.push_back(good11[i]);
        make_good(8, 8'h42, fb);
        send_frame(fa, 0, sa);
        send_frame(fb, 0, sbb);
        idle(2);
        wait_verdicts();
        total++;
        if (sa !== 0 || sbb !== 1)
            $display("FAIL b2b_bubble: got %0d/%0d stalls want 0/1", sa, sbb);
        else passed++;
        total++;
        if (ok_count !== 16'd2 || err_count !== 16'd0)
            $display("FAIL b2b_counts: got ok=%0d err=%0d want 2 0", ok_count, err_count);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] f[$];
        int st;
        for (int i = 0; i < 5; i++) send_byte(good11[i], 1'b0, 0, st);
        do_reset();
        total++;
        if (ok_count !== 16'd0 || err_count !== 16'd0 || crc_residue !== 16'hFFFF)
            $display("FAIL midreset_clear: got ok=%0d err=%0d res=%h want 0 0 ffff",
                     ok_count, err_count, crc_residue);
        else passed++;
        foreach (good11[i]) f.push_back(good11[i]);
        send_frame(f, 0, st);
        idle(2);
        wait_verdicts();
        total++;
        if (ok_count !== 16'd1 || err_count !== 16'd0)
            $display("FAIL midreset_counts: got ok=%0d err=%0d want 1 0", ok_count, err_count);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        test_reset();
        test_good();
        test_crc_err();
        test_runt();
        test_oversize();
        test_boundary();
        test_back_to_back();
        test_reset_mid_frame();
        idle(3);
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/crc_ccitt_frame_checker.md
# crc_ccitt_frame_checker

Receive-side companion to the 8-bit parallel CCITT CRC generator. It accepts a byte stream framed by a last flag, runs CRC-16-CCITT over every byte including the two trailing CRC bytes, and reports one pass/fail verdict per frame. It also reports frame length, flags runt and oversize frames, and keeps saturating good and bad frame counters. It sits between the byte deserializer and the frame buffer's commit/discard logic.

## Interface
- MAX_LEN, 1024: maximum accepted frame length in bytes, including the 2 CRC bytes.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  input byte valid.
- s_ready  out  1  checker can accept a byte.
- s_data  in  8  input byte; bit 7 enters the CRC first.
- s_last  in  1  marks the final byte of the frame (the CRC LSB byte).
- frame_valid  out  1  one-cycle verdict pulse.
- frame_ok  out  1  verdict; meaningful only while frame_valid=1.
- frame_err_code  out  2  00 ok, 01 CRC mismatch, 10 runt, 11 oversize.
- frame_len  out  16  byte count of the frame, including CRC bytes; saturates at 16'hFFFF.
- crc_residue  out  16  final CRC register value for the frame.
- ok_count  out  CNT_W  saturating count of good frames.
- err_count  out  CNT_W  saturating count of bad frames.

## Operation
- CRC definition:
  - Polynomial 0x1021, init 16'hFFFF, MSB-first, no reflection, no final XOR.
  - The sender appends the CRC MSB byte first.
  - A good frame therefore leaves residue 16'h0000.
- Beat transfer: a byte is taken when s_valid && s_ready.
- FSM states:
  - IDLE: s_ready=1; crc=FFFF, len=0. An accepted byte enters DATA, or RESULT if s_last=1.
  - DATA: s_ready=1.
    - Each accepted byte updates crc and increments len.
    - An accepted byte with s_last=1 goes to RESULT.
    - An accepted byte with no s_last that makes len exceed MAX_LEN goes to DRAIN.
  - DRAIN: s_ready=1; bytes are discarded and crc is frozen; len keeps counting (saturating). s_last goes to RESULT with the oversize flag set.
  - RESULT: s_ready=0 for exactly one cycle; frame_valid=1 and counters update. Always returns to IDLE.
- Verdict priority: oversize > runt > CRC mismatch > ok.
  - Runt: len < 3, i.e. no payload byte.
  - Oversize: len > MAX_LEN. A frame whose s_last byte lands exactly at len = MAX_LEN+1 is also oversize.
- Counters saturate at all ones and never wrap.
- s_valid=0 cycles mid-frame are legal gaps; state and crc hold.
- Reset values:
  - state IDLE, s_ready=1 (the first cycle after reset may accept).
  - frame_valid=0, frame_ok=0, frame_err_code=0, frame_len=0, crc_residue=FFFF, counters 0.
- Reset mid-frame abandons the frame: no verdict, and counters are cleared.

## Timing
- Last byte accepted in cycle N → frame_valid=1 in cycle N+1, with all verdict outputs registered.
- The next frame's first byte is accepted no earlier than cycle N+2.
- frame_ok, frame_err_code, frame_len and crc_residue hold their values until the next verdict.
- Throughput: 1 byte/cycle, plus one bubble per frame.
- s_ready depends only on state. There is no combinational path from s_valid to s_ready.

## Structure
- Package crc_ccitt_pkg:
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
  - Error-code enum.
  - Function crc_ccitt_byte(crc, data) returning the next 16-bit CRC. Shared with the generator so both ends stay bit-identical.
- Sub-module crc16_ccitt_byte: a combinational wrapper of that function, fully specified for all 16 output bits. The checker instantiates it once.
- Everything else (FSM, length counter, statistics) lives in the top module.

## Test plan
- Bytes 31 32 33 34 35 36 37 38 39 29 B1, s_last on B1 → frame_valid one cycle later:
  - frame_ok=1, code 00, frame_len=11, crc_residue=0000, ok_count=1.
- Same frame with B1 changed to B0 → frame_ok=0, code 01, crc_residue≠0000, err_count=1.
- Two-byte frame 29 B1 → code 10 (runt), frame_len=2.
- MAX_LEN=16, a 20-byte frame → s_ready stays 1 through the drain; then code 11, frame_len=20, err_count increments once.
- Back-to-back good frames with s_valid held at 1:
  - exactly one s_ready=0 bubble between frames;
  - both verdicts are ok; ok_count=2.
- Reset asserted after byte 5 of a good frame, then the full good frame resent:
  - no verdict for the aborted frame;
  - one ok verdict; counters ok=1, err=0.
